xs3_bcd_seq_ctrl: RTL
=====================

// Module: xs3_bcd_seq_ctrl
// PURPOSE
//  Sequencing controller for the 4-bit Excess-3 -> BCD digit converter.
//  Accepts a packed multi-digit Excess-3 word over a valid/ready handshake.
//  Time-shares ONE converter instance across all digits, one digit per clock, LSD first.
//  Returns the packed BCD word with per-digit code-error flags over a second valid/ready handshake.
//  Sits between the XS3 input source and the BCD display/arith path.
// PARAMETERS
//  DIGITS  4  number of 4-bit digits per word (>=1)
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  in_valid     in   1          in_xs3 holds a word to convert
//  in_ready     out  1          controller can capture a word
//  in_xs3       in   4*DIGITS   packed XS3 word, digit k = [4k+3:4k]
//  out_valid    out  1          out_bcd/out_err valid
//  out_ready    in   1          sink accepts result
//  out_bcd      out  4*DIGITS   packed BCD result, same digit order
//  out_err      out  DIGITS     bit k = 1 if digit k was not a legal XS3 code
//  busy         out  1          high in CONV or DONE
// BEHAVIOUR
//  - Reset (async assert, any state): state=IDLE, idx=0, in_ready=1, out_valid=0,
//    out_bcd=0, out_err=0, busy=0. A word in flight is discarded, with no partial output.
//  - FSM states: IDLE, CONV, DONE.
//  - IDLE: in_ready=1.
//      in_valid&&in_ready at edge -> capture in_xs3 into shift reg, clear out_err and out_bcd,
//      idx=0, go to CONV.
//  - CONV: in_ready=0.
//      Each edge converts digit idx through the shared converter (b = e - 3) and writes
//      result digit idx.
//      At idx==DIGITS-1 the write occurs and state goes to DONE. Otherwise idx++.
//  - Legal XS3 codes are 4'h3..4'hC.
//      For codes 0,1,2,D,E,F, set out_err[idx]=1 and force result digit idx to 4'hF.
//      The controller does not use raw converter output for these codes.
//  - DONE: out_valid=1, and out_bcd/out_err are held stable.
//      out_valid&&out_ready at edge -> out_valid=0, go to IDLE.
//      out_ready low -> hold indefinitely.
//  - Latency: capture at edge 0, last digit written at edge DIGITS, out_valid high from
//    edge DIGITS.
//  - Throughput: one word per DIGITS+2 cycles minimum.
//  - No back-to-back capture: in_ready is low in DONE, even if out_ready and in_valid are both high.
//    A new capture is possible at the earliest on the edge after the output handshake.
//  - in_xs3 is sampled only at capture. Changes during CONV/DONE have no effect.
//  - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  - idx width: clog2(DIGITS), min 1 bit. idx never exceeds DIGITS-1 and returns to 0 on capture.
//  - DIGITS==1: CONV lasts exactly one cycle.
// TESTING (DIGITS=4)
//  1. rst pulse mid-CONV (after 2 digits) -> outputs immediately at reset values.
//     Next capture converts cleanly.
//  2. in_xs3=16'h4C83, out_ready=1 -> out_valid rises 4 edges after capture.
//     Expect out_bcd=16'h1950, out_err=4'b0000.
//  3. in_xs3=16'h4F83 -> out_bcd=16'h1F50, out_err=4'b0100.
//     in_xs3=16'h0000 -> out_bcd=16'hFFFF, out_err=4'b1111.
//  4. out_ready held low 10 cycles in DONE -> out_valid and out_bcd stable, in_ready=0.
//     Raise out_ready -> IDLE next edge.
//  5. in_valid held high continuously with words 16'h3333 and 16'hCCCC.
//     Expect 16'h0000 then 16'h9999, with 6-cycle spacing between captures.
//  6. Bounds: in_xs3=16'h3C3C -> 16'h0909, err 0.
//     Change in_xs3 during CONV -> result unaffected.

Source files
------------

// File: rtl/xs3_bcd_seq_ctrl.sv
// xs3_bcd_seq_ctrl: multi-digit Excess-3 to BCD sequencing controller.
//   Captures a packed XS3 word over a valid/ready handshake. One shared digit
//   converter is time-shared across the digits, one digit per clock, least
//   significant digit first. The packed BCD word and per-digit code-error
//   flags are returned over a second valid/ready handshake.
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_xs3 digit k = [4k+3:4k]
//   out_valid/out_ready   output handshake for out_bcd / out_err
//   out_bcd               packed BCD result, same digit order as in_xs3
//   out_err               bit k set when digit k was not a legal XS3 code
//   busy                  high while converting or holding a result

// Single-digit converter: BCD = XS3 - 3 (raw; legality is checked by caller).
module xs3_bcd_digit (
  input  logic [3:0] xs3_i,
  output logic [3:0] bcd_o
);
  assign bcd_o = xs3_i - 4'd3;
endmodule

module xs3_bcd_seq_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_xs3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err,
  output logic                  busy
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       xs3_q;
  logic [W-1:0]       bcd_q;
  logic [DIGITS-1:0]  err_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [3:0]         conv_bcd;
  logic [3:0]         digit_d;
  logic               legal_c;
  logic               last_c;
  logic [W-1:0]       bcd_d;
  logic [DIGITS-1:0]  err_d;

  // The captured word shifts right each cycle, so the current digit is always the low nibble.
  xs3_bcd_digit u_conv (
    .xs3_i (xs3_q[3:0]),
    .bcd_o (conv_bcd)
  );

  // Illegal codes are replaced by 4'hF rather than using the raw converter output.
  always_comb begin
    legal_c = (xs3_q[3:0] >= 4'h3) && (xs3_q[3:0] <= 4'hC);
    digit_d = legal_c ? conv_bcd : 4'hF;
    last_c  = (idx_q == IDX_W'(DIGITS - 1));
    bcd_d   = bcd_q;
    err_d   = err_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        bcd_d[4*k +: 4] = digit_d;
        err_d[k]        = ~legal_c;
      end
    end
  end

  // Controller FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      xs3_q       <= '0;
      bcd_q       <= '0;
      err_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            xs3_q      <= in_xs3;
            bcd_q      <= '0;
            err_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          err_q <= err_d;
          xs3_q <= xs3_q >> 4;
          if (last_c) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          // in_ready stays low here; a new capture waits for the edge after the handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = bcd_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

endmodule
